// File: rtl/oq_input_arbiter.sv
// Packet-granular round-robin merge of five AXI-Stream inputs onto one master stream.
// Handshake: a beat moves on any port only in a cycle where tvalid and tready are both high at the rising edge.
module oq_input_arbiter #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXI_DATA_WIDTH   = 32
) (
  input  logic                              axi_aclk,
  input  logic                              axi_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_0,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_0,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_0,
  input  logic                              s_axis_tvalid_0,
  input  logic                              s_axis_tlast_0,
  output logic                              s_axis_tready_0,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_1,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_1,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_1,
  input  logic                              s_axis_tvalid_1,
  input  logic                              s_axis_tlast_1,
  output logic                              s_axis_tready_1,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_2,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_2,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_2,
  input  logic                              s_axis_tvalid_2,
  input  logic                              s_axis_tlast_2,
  output logic                              s_axis_tready_2,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_3,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_3,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_3,
  input  logic                              s_axis_tvalid_3,
  input  logic                              s_axis_tlast_3,
  output logic                              s_axis_tready_3,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_4,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_4,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_4,
  input  logic                              s_axis_tvalid_4,
  input  logic                              s_axis_tlast_4,
  output logic                              s_axis_tready_4,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [4:0]                        pkt_granted,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     bytes_granted,
  output logic                              arb_state
);

  // Master and slave widths are expected to match; the data path is a pure mux.
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic [2:0] cur, cur_nxt;
  logic [2:0] last_grant, last_grant_nxt;
  logic [2:0] winner;
  logic       grant_found;
  logic [4:0] pkt_granted_nxt;
  logic [C_S_AXI_DATA_WIDTH-1:0] bytes_granted_nxt;
  logic [4:0] ready_vec;

  logic [DW-1:0] in_data [5];
  logic [SW-1:0] in_strb [5];
  logic [UW-1:0] in_user [5];
  logic [4:0]    in_valid;
  logic [4:0]    in_last;

  assign in_data[0] = s_axis_tdata_0;
  assign in_data[1] = s_axis_tdata_1;
  assign in_data[2] = s_axis_tdata_2;
  assign in_data[3] = s_axis_tdata_3;
  assign in_data[4] = s_axis_tdata_4;
  assign in_strb[0] = s_axis_tstrb_0;
  assign in_strb[1] = s_axis_tstrb_1;
  assign in_strb[2] = s_axis_tstrb_2;
  assign in_strb[3] = s_axis_tstrb_3;
  assign in_strb[4] = s_axis_tstrb_4;
  assign in_user[0] = s_axis_tuser_0;
  assign in_user[1] = s_axis_tuser_1;
  assign in_user[2] = s_axis_tuser_2;
  assign in_user[3] = s_axis_tuser_3;
  assign in_user[4] = s_axis_tuser_4;
  assign in_valid   = {s_axis_tvalid_4, s_axis_tvalid_3, s_axis_tvalid_2,
                       s_axis_tvalid_1, s_axis_tvalid_0};
  assign in_last    = {s_axis_tlast_4, s_axis_tlast_3, s_axis_tlast_2,
                       s_axis_tlast_1, s_axis_tlast_0};

  assign s_axis_tready_0 = ready_vec[0];
  assign s_axis_tready_1 = ready_vec[1];
  assign s_axis_tready_2 = ready_vec[2];
  assign s_axis_tready_3 = ready_vec[3];
  assign s_axis_tready_4 = ready_vec[4];
  assign arb_state       = (state == LOCKED);

  function automatic logic [2:0] rr_idx(input logic [2:0] base, input logic [2:0] off);
    logic [3:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 4'd5) s = s - 4'd5;
    return s[2:0];
  endfunction

  // Search starts just after the last winner so every requester is reached within five grants.
  always_comb begin
    winner      = last_grant;
    grant_found = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (!grant_found && in_valid[rr_idx(last_grant, 3'(i))]) begin
        winner      = rr_idx(last_grant, 3'(i));
        grant_found = 1'b1;
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state         <= IDLE;
      cur           <= 3'd0;
      last_grant    <= 3'd4;
      pkt_granted   <= 5'd0;
      bytes_granted <= '0;
    end else begin
      state         <= state_nxt;
      cur           <= cur_nxt;
      last_grant    <= last_grant_nxt;
      pkt_granted   <= pkt_granted_nxt;
      bytes_granted <= bytes_granted_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    cur_nxt           = cur;
    last_grant_nxt    = last_grant;
    pkt_granted_nxt   = 5'd0;
    bytes_granted_nxt = '0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          state_nxt                 = LOCKED;
          cur_nxt                   = winner;
          last_grant_nxt            = winner;
          pkt_granted_nxt[winner]   = 1'b1;
          bytes_granted_nxt         = C_S_AXI_DATA_WIDTH'(in_user[winner][15:0]);
        end
      end
      LOCKED: begin
        if (in_valid[cur] && m_axis_tready && in_last[cur]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Payload follows cur even when idle; only tvalid and the readies are gated by state.
  always_comb begin
    m_axis_tdata  = in_data[cur];
    m_axis_tstrb  = in_strb[cur];
    m_axis_tuser  = in_user[cur];
    m_axis_tlast  = in_last[cur];
    m_axis_tvalid = 1'b0;
    ready_vec     = 5'd0;
    if (state == LOCKED) begin
      m_axis_tvalid  = in_valid[cur];
      ready_vec[cur] = m_axis_tready;
    end
  end

endmodule

// File: tb/tb_oq_input_arbiter.sv
// Randomized bench for oq_input_arbiter: per-input drivers feed a scoreboard that a negedge monitor drains.
module tb_oq_input_arbiter;

  localparam int DW = 256;
  localparam int SW = DW / 8;
  localparam int UW = 128;
  localparam int AW = 32;
  localparam int BW = DW + UW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] tdata [5];
  logic [SW-1:0] tstrb [5];
  logic [UW-1:0] tuser [5];
  logic          tvalid [5];
  logic          tlast [5];
  logic [4:0]    s_ready;
  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid, m_tlast, m_ready;
  logic [4:0]    pkt_granted;
  logic [AW-1:0] bytes_granted;
  logic          arb_state;

  oq_input_arbiter dut (
    .axi_aclk(clk), .axi_resetn(resetn),
    .s_axis_tdata_0(tdata[0]), .s_axis_tstrb_0(tstrb[0]), .s_axis_tuser_0(tuser[0]),
    .s_axis_tvalid_0(tvalid[0]), .s_axis_tlast_0(tlast[0]), .s_axis_tready_0(s_ready[0]),
    .s_axis_tdata_1(tdata[1]), .s_axis_tstrb_1(tstrb[1]), .s_axis_tuser_1(tuser[1]),
    .s_axis_tvalid_1(tvalid[1]), .s_axis_tlast_1(tlast[1]), .s_axis_tready_1(s_ready[1]),
    .s_axis_tdata_2(tdata[2]), .s_axis_tstrb_2(tstrb[2]), .s_axis_tuser_2(tuser[2]),
    .s_axis_tvalid_2(tvalid[2]), .s_axis_tlast_2(tlast[2]), .s_axis_tready_2(s_ready[2]),
    .s_axis_tdata_3(tdata[3]), .s_axis_tstrb_3(tstrb[3]), .s_axis_tuser_3(tuser[3]),
    .s_axis_tvalid_3(tvalid[3]), .s_axis_tlast_3(tlast[3]), .s_axis_tready_3(s_ready[3]),
    .s_axis_tdata_4(tdata[4]), .s_axis_tstrb_4(tstrb[4]), .s_axis_tuser_4(tuser[4]),
    .s_axis_tvalid_4(tvalid[4]), .s_axis_tlast_4(tlast[4]), .s_axis_tready_4(s_ready[4]),
    .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_ready),
    .pkt_granted(pkt_granted), .bytes_granted(bytes_granted), .arb_state(arb_state)
  );

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_q [5][$];
  int            grant_log[$];
  int            checks = 0;
  int            errors = 0;
  bit            mon_en = 1'b0;
  int            rdy_mode = 0;
  int            beats_out = 0;
  int            seq [5];

  // Reference model: which input owns the master port and which one was served last.
  bit            mdl_locked;
  int            mdl_cur;
  int            mdl_last;
  int            mon_c;
  logic [4:0]    mdl_pulse;
  logic [AW-1:0] mdl_bytes;
  logic [4:0]    exp_rdy;

  function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!resetn) begin
      mdl_locked = 1'b0;
      mdl_cur    = 0;
      mdl_last   = 4;
      mdl_pulse  = '0;
      mdl_bytes  = '0;
    end else if (mon_en) begin
      chk("pkt_granted", pkt_granted, mdl_pulse);
      chk("bytes_granted", bytes_granted, mdl_bytes);
      chk("state_dbg", arb_state, mdl_locked);
      mdl_pulse = '0;
      mdl_bytes = '0;
      if (!mdl_locked) begin
        chk("idle_tvalid", m_tvalid, 1'b0);
        chk("idle_tready", s_ready, 5'd0);
        for (int k = 1; k <= 5; k++) begin
          mon_c = (mdl_last + k) % 5;
          if (!mdl_locked && tvalid[mon_c]) begin
            mdl_locked         = 1'b1;
            mdl_cur            = mon_c;
            mdl_last           = mon_c;
            mdl_pulse[mon_c]   = 1'b1;
            mdl_bytes          = AW'(tuser[mon_c][15:0]);
            grant_log.push_back(mon_c);
          end
        end
      end else begin
        exp_rdy          = '0;
        exp_rdy[mdl_cur] = m_ready;
        chk("tready_route", s_ready, exp_rdy);
        chk("tvalid_follow", m_tvalid, tvalid[mdl_cur]);
        chk("tstrb_follow", m_tstrb, tstrb[mdl_cur]);
        if (tvalid[mdl_cur] && m_ready) begin
          beats_out++;
          if (exp_q[mdl_cur].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat_unexpected: input %0d got %0h expected no beat", mdl_cur, m_tdata);
          end else begin
            chk("beat", {m_tlast, m_tuser, m_tdata}, exp_q[mdl_cur].pop_front());
          end
          if (tlast[mdl_cur]) mdl_locked = 1'b0;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       m_ready = ~m_ready;
        2:       m_ready = 1'($urandom_range(1, 0));
        default: m_ready = 1'b1;
      endcase
    end
  end

  task automatic reset_dut();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // len < 0 picks a random length; gap_beat >= 0 holds tvalid low gap_len cycles before that beat.
  task automatic drive_input(input int n, input int npkts, input int bmin, input int bmax,
                             input int len, input int gap_beat, input int gap_len, input bit rand_gaps);
    int nb, g, waited;
    bit hs;
    logic [15:0] l;
    logic [UW-1:0] usr;
    logic [DW-1:0] d;
    for (int p = 0; p < npkts; p++) begin
      nb = int'($urandom_range(32'(bmax), 32'(bmin)));
      l = (len < 0) ? 16'($urandom) : 16'(len);
      usr = {$urandom, $urandom, $urandom, $urandom};
      usr[15:0] = l;
      for (int b = 0; b < nb; b++) begin
        g = (b == gap_beat) ? gap_len : (rand_gaps ? int'($urandom_range(2, 0)) : 0);
        if (g > 0) begin
          tvalid[n] = 1'b0;
          repeat (g) begin
            @(posedge clk);
            #1;
          end
        end
        d = rand_word();
        d[DW-1 -: 8]  = 8'(n);
        d[DW-9 -: 16] = 16'(seq[n]);
        seq[n]++;
        tdata[n]  = d;
        tstrb[n]  = $urandom;
        tuser[n]  = usr;
        tlast[n]  = (b == nb - 1);
        tvalid[n] = 1'b1;
        exp_q[n].push_back({tlast[n], usr, d});
        waited = 0;
        forever begin
          @(negedge clk);
          hs = s_ready[n];
          @(posedge clk);
          #1;
          if (hs) break;
          waited++;
          if (waited > 2000) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: input %0d beat %0d got no tready in 2000 cycles, expected handshake", n, b);
            break;
          end
        end
      end
    end
    tvalid[n] = 1'b0;
    tlast[n]  = 1'b0;
  endtask

  task automatic verify_phase(input string name, input int ord[$]);
    repeat (4) @(posedge clk);
    #1;
    if (ord.size() > 0) begin
      chk({name, "_grant_count"}, grant_log.size(), ord.size());
      for (int i = 0; i < ord.size() && i < grant_log.size(); i++)
        chk({name, "_grant_order"}, grant_log[i], ord[i]);
    end
    for (int i = 0; i < 5; i++) chk({name, "_drained"}, exp_q[i].size(), 0);
    grant_log.delete();
  endtask

  // ---------------- main sequence ----------------
  int ord[$];
  int b0;
  logic [DW-1:0] beat2;

  initial begin
    for (int i = 0; i < 5; i++) begin
      tdata[i] = '0; tstrb[i] = '0; tuser[i] = '0; tvalid[i] = 1'b0; tlast[i] = 1'b0; seq[i] = 0;
    end
    @(posedge clk);
    #1;
    reset_dut();
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // All five inputs request at once after reset.
    fork
      drive_input(0, 2, 2, 2, 64, -1, 0, 1'b0);
      drive_input(1, 1, 2, 2, 64, -1, 0, 1'b0);
      drive_input(2, 1, 2, 2, 64, -1, 0, 1'b0);
      drive_input(3, 1, 2, 2, 64, -1, 0, 1'b0);
      drive_input(4, 1, 2, 2, 64, -1, 0, 1'b0);
    join
    ord = {0, 1, 2, 3, 4, 0};
    verify_phase("rr_all", ord);

    // Single requester with back-to-back 128-byte packets.
    drive_input(3, 3, 4, 4, 128, -1, 0, 1'b0);
    ord = {3, 3, 3};
    verify_phase("solo3", ord);

    // Input 1 stalls mid-packet while input 2 waits.
    fork
      drive_input(1, 1, 4, 4, 100, 2, 3, 1'b0);
      drive_input(2, 1, 2, 2, 50, -1, 0, 1'b0);
    join
    ord = {1, 2};
    verify_phase("stall", ord);

    // Alternating master backpressure over an 8-beat packet.
    rdy_mode = 1;
    b0 = beats_out;
    drive_input(0, 1, 8, 8, 256, -1, 0, 1'b0);
    rdy_mode = 0;
    ord = {0};
    verify_phase("toggle", ord);
    chk("toggle_beats", beats_out - b0, 8);

    // Random traffic on every input with random backpressure and gaps.
    rdy_mode = 2;
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 5; n++) begin
        automatic int k = n;
        fork
          drive_input(k, int'($urandom_range(4, 1)), 1, 6, -1, -1, 0, 1'b1);
        join_none
      end
      wait fork;
      ord.delete();
      verify_phase("random", ord);
    end
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset during beat 2 of a 5-beat packet on input 4.
    mon_en = 1'b0;
    tdata[4] = rand_word(); tuser[4] = 128'h50; tlast[4] = 1'b0; tvalid[4] = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_grant4", pkt_granted, 5'b10000);
    chk("rst_beat1_valid", m_tvalid, 1'b1);
    @(posedge clk);
    #1;
    beat2 = rand_word();
    tdata[4] = beat2;
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_beat2_data", m_tdata, beat2);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    tdata[0] = rand_word(); tuser[0] = 128'h40; tlast[0] = 1'b0; tvalid[0] = 1'b1;
    @(negedge clk);
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_tready", s_ready, 5'd0);
    chk("rst_pkt_granted", pkt_granted, 5'd0);
    chk("rst_bytes", bytes_granted, 32'd0);
    chk("rst_state", arb_state, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_regrant0", pkt_granted, 5'b00001);
    chk("rst_regrant_bytes", bytes_granted, 32'h40);
    chk("rst_regrant_data", m_tdata, tdata[0]);
    chk("rst_regrant_ready", s_ready, 5'b00001);
    @(posedge clk);
    #1;
    tvalid[0] = 1'b0;
    tvalid[4] = 1'b0;
    reset_dut();
    for (int i = 0; i < 5; i++) exp_q[i].delete();
    grant_log.delete();
    mon_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation reached time limit, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
